// File: rtl/riscv_bpu_if.sv
// -----------------------------------------------------------------------------
// riscv_bpu_if
// Groups the fetch-lookup, execute-update and statistics signals of the
// branch prediction unit into one bundle.
//   master : the pipeline side (fetch supplies the PC; execute supplies the
//            resolved branch and consumes mispredict/redirect)
//   slave  : the riscv_bpu side
// Signals:
//   i_riscv_bpu_fetch_pc        fetch PC to predict
//   o_riscv_bpu_pred_taken/_target   prediction back to fetch
//   i_riscv_bpu_upd_*           resolved branch and its piped prediction
//   o_riscv_bpu_mispredict/redirect_pc  flush/redirect request to execute
//   o_riscv_bpu_branch_cnt/mispred_cnt  statistics (zero unless built in)
// -----------------------------------------------------------------------------
interface riscv_bpu_if;
    logic [63:0] i_riscv_bpu_fetch_pc;
    logic        o_riscv_bpu_pred_taken;
    logic [63:0] o_riscv_bpu_pred_target;
    logic        i_riscv_bpu_upd_valid;
    logic [63:0] i_riscv_bpu_upd_pc;
    logic        i_riscv_bpu_upd_taken;
    logic [63:0] i_riscv_bpu_upd_target;
    logic        i_riscv_bpu_upd_pred_taken;
    logic [63:0] i_riscv_bpu_upd_pred_target;
    logic        o_riscv_bpu_mispredict;
    logic [63:0] o_riscv_bpu_redirect_pc;
    logic [31:0] o_riscv_bpu_branch_cnt;
    logic [31:0] o_riscv_bpu_mispred_cnt;

    modport master (
        output i_riscv_bpu_fetch_pc,
        input  o_riscv_bpu_pred_taken,
        input  o_riscv_bpu_pred_target,
        output i_riscv_bpu_upd_valid,
        output i_riscv_bpu_upd_pc,
        output i_riscv_bpu_upd_taken,
        output i_riscv_bpu_upd_target,
        output i_riscv_bpu_upd_pred_taken,
        output i_riscv_bpu_upd_pred_target,
        input  o_riscv_bpu_mispredict,
        input  o_riscv_bpu_redirect_pc,
        input  o_riscv_bpu_branch_cnt,
        input  o_riscv_bpu_mispred_cnt
    );

    modport slave (
        input  i_riscv_bpu_fetch_pc,
        output o_riscv_bpu_pred_taken,
        output o_riscv_bpu_pred_target,
        input  i_riscv_bpu_upd_valid,
        input  i_riscv_bpu_upd_pc,
        input  i_riscv_bpu_upd_taken,
        input  i_riscv_bpu_upd_target,
        input  i_riscv_bpu_upd_pred_taken,
        input  i_riscv_bpu_upd_pred_target,
        output o_riscv_bpu_mispredict,
        output o_riscv_bpu_redirect_pc,
        output o_riscv_bpu_branch_cnt,
        output o_riscv_bpu_mispred_cnt
    );
endinterface

// File: rtl/riscv_bpu.sv
// -----------------------------------------------------------------------------
// riscv_bpu
// Branch prediction unit: direct-mapped table of 2-bit saturating direction
// counters plus a tagged branch target buffer. Fetch looks up combinationally
// every cycle; execute trains the table with one resolved branch per cycle and
// gets a combinational mispredict/redirect back.
// Ports:
//   i_riscv_bpu_clk    clock, rising edge
//   i_riscv_bpu_rst_n  synchronous active-low reset
//   bpu                riscv_bpu_if.slave (lookup, update, redirect, stats)
// Optional feature: define RISCV_BPU_STATS_EN to build the saturating
// resolved-branch and mispredict counters; otherwise both count outputs are 0.
// -----------------------------------------------------------------------------
module riscv_bpu #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 10
) (
    input  logic        i_riscv_bpu_clk,
    input  logic        i_riscv_bpu_rst_n,
    riscv_bpu_if.slave  bpu
);
    localparam int ENTRIES = 1 << IDX_W;

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Control state is reset; tags and targets are only meaningful when valid.
    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [63:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;
    logic             upd_en, wr_ctl, wr_data;
    logic [1:0]       ctr_d;
    logic             mispredict;

    // Lookup: reads the array as it stands, so a same-cycle update is not seen.
    always_comb begin
        f_idx = bpu.i_riscv_bpu_fetch_pc[IDX_W+1:2];
        f_tag = bpu.i_riscv_bpu_fetch_pc[TAG_W+IDX_W+1:IDX_W+2];
        f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        bpu.o_riscv_bpu_pred_taken  = i_riscv_bpu_rst_n && f_hit && ctr_q[f_idx][1];
        bpu.o_riscv_bpu_pred_target = bpu.o_riscv_bpu_pred_taken ? tgt_q[f_idx]
                                    : bpu.i_riscv_bpu_fetch_pc + 64'd4;
    end

    // Update decode: a miss only allocates on a taken branch, at weakly taken.
    always_comb begin
        u_idx   = bpu.i_riscv_bpu_upd_pc[IDX_W+1:2];
        u_tag   = bpu.i_riscv_bpu_upd_pc[TAG_W+IDX_W+1:IDX_W+2];
        u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        upd_en  = bpu.i_riscv_bpu_upd_valid && i_riscv_bpu_rst_n;
        ctr_d   = 2'b10;
        if (u_hit) begin
            ctr_d = bpu.i_riscv_bpu_upd_taken ? ctr_sat_inc(ctr_q[u_idx])
                                              : ctr_sat_dec(ctr_q[u_idx]);
        end
        wr_ctl  = upd_en && (u_hit || bpu.i_riscv_bpu_upd_taken);
        wr_data = upd_en && bpu.i_riscv_bpu_upd_taken;
    end

    always_ff @(posedge i_riscv_bpu_clk) begin
        if (!i_riscv_bpu_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (wr_ctl) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_d;
        end
    end

    always_ff @(posedge i_riscv_bpu_clk) begin
        if (wr_data) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= bpu.i_riscv_bpu_upd_target;
        end
    end

    // Mispredict: wrong direction, or right "taken" with the wrong target.
    always_comb begin
        mispredict = upd_en &&
                     ((bpu.i_riscv_bpu_upd_taken != bpu.i_riscv_bpu_upd_pred_taken) ||
                      (bpu.i_riscv_bpu_upd_taken &&
                       (bpu.i_riscv_bpu_upd_target != bpu.i_riscv_bpu_upd_pred_target)));
        bpu.o_riscv_bpu_mispredict  = mispredict;
        bpu.o_riscv_bpu_redirect_pc = bpu.i_riscv_bpu_upd_taken ? bpu.i_riscv_bpu_upd_target
                                    : bpu.i_riscv_bpu_upd_pc + 64'd4;
    end

`ifdef RISCV_BPU_STATS_EN
    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = upd_en ? cnt_sat_inc(branch_cnt_q) : branch_cnt_q;
        mispred_cnt_d = mispredict ? cnt_sat_inc(mispred_cnt_q) : mispred_cnt_q;
    end

    always_ff @(posedge i_riscv_bpu_clk) begin
        if (!i_riscv_bpu_rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bpu.o_riscv_bpu_branch_cnt  = branch_cnt_q;
    assign bpu.o_riscv_bpu_mispred_cnt = mispred_cnt_q;
`else
    assign bpu.o_riscv_bpu_branch_cnt  = 32'd0;
    assign bpu.o_riscv_bpu_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_bpu.sv
// -----------------------------------------------------------------------------
// tb_riscv_bpu
// Directed scoreboard bench for riscv_bpu (IDX_W=6, TAG_W=10). The driver
// applies one vector per cycle and queues the hand-computed outputs it
// expects for that cycle; the monitor drains the queue at the falling edge.
// -----------------------------------------------------------------------------
module tb_riscv_bpu;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    riscv_bpu_if bif ();

    riscv_bpu #(.IDX_W(6), .TAG_W(10)) dut (
        .i_riscv_bpu_clk   (clk),
        .i_riscv_bpu_rst_n (rst_n),
        .bpu               (bif.slave)
    );

`ifdef RISCV_BPU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int S_PT = 0, S_PTGT = 1, S_MP = 2, S_RD = 3, S_BC = 4, S_MC = 5;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [63:0] stat_exp(input logic [63:0] v);
        return STATS ? v : 64'd0;
    endfunction

    task automatic chk(input int sel, input logic [63:0] v, input string nm);
        exp_t e;
        e.sel = sel; e.exp = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic rn, input logic [63:0] fpc,
                         input logic uv, input logic [63:0] upc, input logic ut,
                         input logic [63:0] utgt, input logic upt, input logic [63:0] uptgt);
        @(posedge clk);
        #1;
        rst_n                           = rn;
        bif.i_riscv_bpu_fetch_pc        = fpc;
        bif.i_riscv_bpu_upd_valid       = uv;
        bif.i_riscv_bpu_upd_pc          = upc;
        bif.i_riscv_bpu_upd_taken       = ut;
        bif.i_riscv_bpu_upd_target      = utgt;
        bif.i_riscv_bpu_upd_pred_taken  = upt;
        bif.i_riscv_bpu_upd_pred_target = uptgt;
    endtask

    // Monitor: compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                S_PT:    act = {63'd0, bif.o_riscv_bpu_pred_taken};
                S_PTGT:  act = bif.o_riscv_bpu_pred_target;
                S_MP:    act = {63'd0, bif.o_riscv_bpu_mispredict};
                S_RD:    act = bif.o_riscv_bpu_redirect_pc;
                S_BC:    act = {32'd0, bif.o_riscv_bpu_branch_cnt};
                default: act = {32'd0, bif.o_riscv_bpu_mispred_cnt};
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_miss++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bif.i_riscv_bpu_fetch_pc        = '0;
        bif.i_riscv_bpu_upd_valid       = 1'b0;
        bif.i_riscv_bpu_upd_pc          = '0;
        bif.i_riscv_bpu_upd_taken       = 1'b0;
        bif.i_riscv_bpu_upd_target      = '0;
        bif.i_riscv_bpu_upd_pred_taken  = 1'b0;
        bif.i_riscv_bpu_upd_pred_target = '0;
        repeat (2) @(posedge clk);

        // In reset: outputs gated, and the update is dropped.
        drive(0, 64'h1000, 1, 64'h1000, 1, 64'h2000, 0, 64'h1004);
        chk(S_PT,   0,         "rst_pred_taken");
        chk(S_PTGT, 64'h1004,  "rst_pred_target");
        chk(S_MP,   0,         "rst_mispredict");

        // Out of reset: table empty.
        drive(1, 64'h1000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   0,         "empty_pred_taken");
        chk(S_PTGT, 64'h1004,  "empty_pred_target");
        chk(S_BC,   0,         "empty_branch_cnt");
        chk(S_MC,   0,         "empty_mispred_cnt");

        // Allocate 0x1000 -> 0x2000 (mispredict #1, update #1).
        drive(1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 0, 64'h1004);
        chk(S_MP,   1,         "alloc_mispredict");
        chk(S_RD,   64'h2000,  "alloc_redirect");
        chk(S_PT,   0,         "alloc_same_cycle_pt");

        drive(1, 64'h1000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   1,         "alloc_hit_pt");
        chk(S_PTGT, 64'h2000,  "alloc_hit_target");

        // Not-taken (mispredict #2, update #2): ctr 10 -> 01.
        drive(1, 64'h1000, 1, 64'h1000, 0, 64'h0, 1, 64'h2000);
        chk(S_MP,   1,         "nt1_mispredict");
        chk(S_RD,   64'h1004,  "nt1_redirect");

        // Not-taken, predicted not-taken (update #3): ctr 01 -> 00.
        drive(1, 64'h1000, 1, 64'h1000, 0, 64'h0, 0, 64'h1004);
        chk(S_PT,   0,         "ctr01_pt");
        chk(S_PTGT, 64'h1004,  "ctr01_target");
        chk(S_MP,   0,         "nt2_mispredict");

        // Four taken updates (#4..#7): 00 -> 01 -> 10 -> 11 -> 11.
        drive(1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 1, 64'h2000);
        chk(S_PT,   0,         "ctr00_pt");
        chk(S_MP,   0,         "t1_mispredict");
        drive(1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 1, 64'h2000);
        chk(S_PT,   0,         "ctr01b_pt");
        drive(1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 1, 64'h2000);
        chk(S_PT,   1,         "ctr10_pt");
        chk(S_PTGT, 64'h2000,  "ctr10_target");
        drive(1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 1, 64'h2000);
        chk(S_PT,   1,         "ctr11_pt");
        // One more taken (#8) still saturates at 11.
        drive(1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 1, 64'h2000);
        // Not-taken from 11 lands on 10, still taken (mispredict #3, update #9).
        drive(1, 64'h1000, 1, 64'h1000, 0, 64'h0, 1, 64'h2000);
        chk(S_MP,   1,         "sat_nt_mispredict");
        chk(S_RD,   64'h1004,  "sat_nt_redirect");

        // Alias 0x2000 onto the same index (update #10, no mispredict).
        drive(1, 64'h1000, 1, 64'h2000, 1, 64'h3000, 1, 64'h3000);
        chk(S_PT,   1,         "sat_still_taken");
        chk(S_PTGT, 64'h2000,  "sat_target");
        chk(S_MP,   0,         "alias_mispredict");

        drive(1, 64'h1000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   0,         "alias_old_miss");
        chk(S_PTGT, 64'h1004,  "alias_old_target");
        chk(S_BC,   stat_exp(10), "stats_branch_cnt");
        chk(S_MC,   stat_exp(3),  "stats_mispred_cnt");

        drive(1, 64'h2000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   1,         "alias_new_pt");
        chk(S_PTGT, 64'h3000,  "alias_new_target");

        // Same-cycle lookup and first allocation of 0x3000: no forwarding.
        drive(1, 64'h3000, 1, 64'h3000, 1, 64'h4440, 0, 64'h3004);
        chk(S_PT,   0,         "fwd_same_cycle_pt");
        chk(S_PTGT, 64'h3004,  "fwd_same_cycle_target");
        chk(S_MP,   1,         "fwd_mispredict");

        drive(1, 64'h3000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   1,         "fwd_next_pt");
        chk(S_PTGT, 64'h4440,  "fwd_next_target");

        // 64-bit wrap on fetch and redirect; not-taken miss changes nothing.
        drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   0,         "wrap_pt");
        chk(S_PTGT, 64'h0,     "wrap_target");
        chk(S_RD,   64'h0,     "wrap_redirect");
        chk(S_MP,   0,         "wrap_mispredict");

        // Direction right, target wrong: mispredict and retarget.
        drive(1, 64'h3000, 1, 64'h3000, 1, 64'h5000, 1, 64'h4440);
        chk(S_MP,   1,         "tgt_mispredict");
        chk(S_RD,   64'h5000,  "tgt_redirect");

        drive(1, 64'h3000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PTGT, 64'h5000,  "retarget");

        // Reset together with an update: reset wins.
        drive(0, 64'h3000, 1, 64'h3000, 1, 64'h6000, 0, 64'h0);
        chk(S_PT,   0,         "rst2_pt");
        chk(S_PTGT, 64'h3004,  "rst2_target");
        chk(S_MP,   0,         "rst2_mispredict");

        drive(1, 64'h3000, 0, 64'h0, 0, 64'h0, 0, 64'h0);
        chk(S_PT,   0,         "post_rst_pt");
        chk(S_BC,   0,         "post_rst_branch_cnt");
        chk(S_MC,   0,         "post_rst_mispred_cnt");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/riscv_bpu.md
# riscv_bpu

Branch prediction unit: the consumer of the resolved branch outcome from the execute-stage branch comparator (`o_riscv_branch_taken`), and the producer of next-PC predictions for fetch. It holds a direct-mapped branch history table of 2-bit saturating counters and a tagged branch target buffer. Fetch does a lookup every cycle. Execute trains the tables with the resolved direction and target, and receives the mispredict/redirect indication.

## Interface
- `IDX_W`, 6: index width; 2^IDX_W entries.
- `TAG_W`, 10: tag width per entry.
- `i_riscv_bpu_clk` in 1: clock, rising edge.
- `i_riscv_bpu_rst_n` in 1: reset, synchronous, active-low.
- `i_riscv_bpu_fetch_pc` in 64: fetch-stage PC to predict.
- `o_riscv_bpu_pred_taken` out 1: predicted taken.
- `o_riscv_bpu_pred_target` out 64: predicted next PC.
- `i_riscv_bpu_upd_valid` in 1: resolved conditional branch present in execute this cycle.
- `i_riscv_bpu_upd_pc` in 64: PC of the resolved branch.
- `i_riscv_bpu_upd_taken` in 1: resolved direction, from the branch comparator.
- `i_riscv_bpu_upd_target` in 64: resolved taken target.
- `i_riscv_bpu_upd_pred_taken` in 1: prediction piped along with the branch.
- `i_riscv_bpu_upd_pred_target` in 64: predicted target piped along with the branch.
- `o_riscv_bpu_mispredict` out 1: flush/redirect request.
- `o_riscv_bpu_redirect_pc` out 64: correct next PC when mispredicting.
- `o_riscv_bpu_branch_cnt` out 32: resolved-branch count (see Configuration).
- `o_riscv_bpu_mispred_cnt` out 32: mispredict count (see Configuration).

## Operation
- Address fields:
  - Index = pc[IDX_W+1:2].
  - Tag = pc[TAG_W+IDX_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Each entry holds: `valid`, `tag[TAG_W]`, `ctr[2]`, `target[64]`.
- Lookup is combinational from the current array state:
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = entry target when `pred_taken` is 1, otherwise fetch_pc+4 (64-bit wrap).
- Update happens at the clock edge when `upd_valid` is 1 and `rst_n` is 1:
  - Hit, taken: ctr is incremented, saturating at 11; target is written with `upd_target`.
  - Hit, not taken: ctr is decremented, saturating at 00; target is unchanged.
  - Miss, taken: the entry is allocated. valid=1, tag written, target=`upd_target`, ctr=10 (weakly taken). Any previous occupant is replaced.
  - Miss, not taken: no change.
- Mispredict is combinational: `mispredict` = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- `redirect_pc` = upd_taken ? upd_target : upd_pc+4. It is driven the same way even when `mispredict`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge): all valid bits are cleared and all ctr are set to 01. Targets and tags are don't-care.
- While `rst_n`=0:
  - `pred_taken`=0.
  - `pred_target`=fetch_pc+4.
  - `mispredict`=0.
  - Updates are ignored.
- Lookup latency: 0 cycles. Update latency: 1 cycle, visible to lookups from the cycle after `upd_valid`.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update entry. No forwarding.
- Reset asserted in the same cycle as `upd_valid`: reset wins and the update is dropped.
- No handshake. Exactly one update can be accepted per cycle, and the producer never stalls.

## Configuration
- `RISCV_BPU_STATS_EN` defined:
  - Two 32-bit counters are built. Both reset to 0 and saturate at 0xFFFF_FFFF.
  - `branch_cnt` increments on every accepted update.
  - `mispred_cnt` increments on every accepted update with `mispredict`=1.
  - Counter outputs are registered and reflect updates one cycle later.
- `RISCV_BPU_STATS_EN` undefined: both count ports stay present and are tied to 32'd0. No counter flops are built.

## Test plan
- Reset, then fetch_pc=0x1000 → `pred_taken`=0, `pred_target`=0x1004, `mispredict`=0.
- Update pc=0x1000, taken=1, target=0x2000, pred_taken=0, for one cycle:
  - Same cycle → `mispredict`=1, `redirect_pc`=0x2000.
  - Next cycle, fetch 0x1000 → `pred_taken`=1, `pred_target`=0x2000.
- Train pc=0x1000 not-taken twice after allocation → ctr goes 10→01→00; fetch gives `pred_taken`=0, `pred_target`=0x1004. Four further taken updates saturate ctr at 11.
- Aliasing, with IDX_W=6, TAG_W=10:
  - Allocate pc=0x1000, then update pc=0x2000 taken (same index, different tag) → 0x2000 replaces the entry.
  - Fetch 0x1000 → miss, `pred_taken`=0.
- Same-cycle lookup and update on the first-time allocation of 0x3000 → lookup returns miss. The following cycle it hits with `pred_target`=upd_target.
- With `RISCV_BPU_STATS_EN` defined, run 10 updates with 3 mispredicts → `branch_cnt`=10, `mispred_cnt`=3. Assert `rst_n`=0 for one edge → both counts read 0.
